// File: rtl/d2b_pkg.sv
// Shared types and widths for the decimal-to-binary game round sequencer.
package d2b_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        PLAY   = 3'd2,
        RESULT = 3'd3,
        OVER   = 3'd4
    } state_t;

    localparam int NUM_W   = 10;
    localparam int LVL_W   = 4;
    localparam int SCORE_W = 10;
    localparam int LIVES_W = 3;
    localparam int STRK_W  = 8;
    localparam int TIME_W  = 8;

    // Low `lvl` bits set: keeps the target inside the range of the current level.
    function automatic logic [NUM_W-1:0] lvl_mask(input logic [LVL_W-1:0] lvl);
        logic [NUM_W-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_W; i++) begin
            m[i] = (i < int'(lvl));
        end
        return m;
    endfunction

endpackage

// File: rtl/d2b_tick_gen.sv
// Round timer prescaler: one-cycle tick every TICK_DIV enabled cycles.
module d2b_tick_gen
    import d2b_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(TICK_DIV - 1));
    assign tick = en && !clr && wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/d2b_game_ctrl.sv
// Round sequencer for the decimal-to-binary game: target latch, round timer,
// answer check and score/streak/lives bookkeeping.
//
//   state  | meaning
//   IDLE   | waiting for start after reset
//   LOAD   | latch masked target, reload round timer (1 cycle)
//   PLAY   | round running, waiting for submit or timeout
//   RESULT | verdict shown on ok/bad for RESULT_CYCLES cycles
//   OVER   | no lives left, waiting for start
module d2b_game_ctrl
    import d2b_pkg::*;
#(
    parameter int TICK_DIV      = 100000,
    parameter int ROUND_TICKS   = 50,
    parameter int RESULT_CYCLES = 50000000,
    parameter int MAX_LEVEL     = 10,
    parameter int STREAK_UP     = 3,
    parameter int LIVES_INIT    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        submit,
    input  logic [9:0]  sw,
    input  logic [9:0]  rng_num,
    output logic [3:0]  level,
    output logic [9:0]  target,
    output logic [7:0]  time_left,
    output logic [9:0]  score,
    output logic [2:0]  lives,
    output logic [2:0]  state,
    output logic        ok,
    output logic        bad
);

    localparam int RW = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

    state_t              st, st_n;
    logic [LVL_W-1:0]    level_n;
    logic [NUM_W-1:0]    target_n;
    logic [TIME_W-1:0]   time_left_n;
    logic [SCORE_W-1:0]  score_n;
    logic [LIVES_W-1:0]  lives_n;
    logic [STRK_W-1:0]   streak, streak_n, streak_inc;
    logic                ok_n, bad_n;
    logic [RW-1:0]       res_cnt, res_cnt_n;
    logic                tick, win, lose, timeout;

    assign state = st;

    d2b_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (st == LOAD),
        .en    (st == PLAY),
        .tick  (tick)
    );

    // The final tick ends the round in the same cycle it empties the timer.
    assign timeout    = (time_left == '0) || (tick && time_left == TIME_W'(1));
    assign streak_inc = streak + STRK_W'(1);

    always_comb begin
        st_n        = st;
        level_n     = level;
        target_n    = target;
        time_left_n = time_left;
        score_n     = score;
        lives_n     = lives;
        streak_n    = streak;
        ok_n        = ok;
        bad_n       = bad;
        res_cnt_n   = res_cnt;
        win         = 1'b0;
        lose        = 1'b0;

        case (st)
            IDLE, OVER: begin
                if (start) begin
                    score_n  = '0;
                    streak_n = '0;
                    lives_n  = LIVES_W'(LIVES_INIT);
                    level_n  = LVL_W'(1);
                    ok_n     = 1'b0;
                    bad_n    = 1'b0;
                    st_n     = LOAD;
                end
            end
            LOAD: begin
                target_n    = rng_num & lvl_mask(level);
                time_left_n = TIME_W'(ROUND_TICKS);
                st_n        = PLAY;
            end
            PLAY: begin
                if (tick && time_left != '0) begin
                    time_left_n = time_left - TIME_W'(1);
                end
                if (submit) begin
                    win  = (sw == target);
                    lose = (sw != target);
                end else if (timeout) begin
                    lose = 1'b1;
                end
            end
            RESULT: begin
                if (res_cnt == '0) begin
                    ok_n  = 1'b0;
                    bad_n = 1'b0;
                    st_n  = (lives == '0) ? OVER : LOAD;
                end else begin
                    res_cnt_n = res_cnt - RW'(1);
                end
            end
            default: st_n = IDLE;
        endcase

        if (win || lose) begin
            st_n      = RESULT;
            res_cnt_n = RW'(RESULT_CYCLES - 1);
            ok_n      = win;
            bad_n     = lose;
        end

        if (win) begin
            if (score != '1) begin
                score_n = score + SCORE_W'(1);
            end
            if (int'(streak_inc) >= STREAK_UP) begin
                if (level < LVL_W'(MAX_LEVEL)) begin
                    level_n  = level + LVL_W'(1);
                    streak_n = '0;
                end else begin
                    streak_n = STRK_W'(STREAK_UP);
                end
            end else begin
                streak_n = streak_inc;
            end
        end

        if (lose) begin
            streak_n = '0;
            if (lives != '0) begin
                lives_n = lives - LIVES_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            level     <= LVL_W'(1);
            target    <= '0;
            time_left <= '0;
            score     <= '0;
            lives     <= LIVES_W'(LIVES_INIT);
            streak    <= '0;
            ok        <= 1'b0;
            bad       <= 1'b0;
            res_cnt   <= '0;
        end else begin
            st        <= st_n;
            level     <= level_n;
            target    <= target_n;
            time_left <= time_left_n;
            score     <= score_n;
            lives     <= lives_n;
            streak    <= streak_n;
            ok        <= ok_n;
            bad       <= bad_n;
            res_cnt   <= res_cnt_n;
        end
    end

endmodule

// File: tb/tb_d2b_game_ctrl.sv
// Self-checking bench for d2b_game_ctrl: game-rule model compared every cycle,
// plus hand-computed checkpoints.
module tb_d2b_game_ctrl;

    localparam int TICK_DIV      = 4;
    localparam int ROUND_TICKS   = 5;
    localparam int RESULT_CYCLES = 2;
    localparam int MAX_LEVEL     = 10;
    localparam int STREAK_UP     = 3;
    localparam int LIVES_INIT    = 3;

    localparam int S_IDLE = 0, S_LOAD = 1, S_PLAY = 2, S_RESULT = 3, S_OVER = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic [9:0] sw = '0;
    logic [9:0] rng_num = 10'h3FF;
    logic [3:0] level;
    logic [9:0] target;
    logic [7:0] time_left;
    logic [9:0] score;
    logic [2:0] lives;
    logic [2:0] state;
    logic       ok;
    logic       bad;

    always #5 clk = ~clk;

    d2b_game_ctrl #(
        .TICK_DIV      (TICK_DIV),
        .ROUND_TICKS   (ROUND_TICKS),
        .RESULT_CYCLES (RESULT_CYCLES),
        .MAX_LEVEL     (MAX_LEVEL),
        .STREAK_UP     (STREAK_UP),
        .LIVES_INIT    (LIVES_INIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .submit    (submit),
        .sw        (sw),
        .rng_num   (rng_num),
        .level     (level),
        .target    (target),
        .time_left (time_left),
        .score     (score),
        .lives     (lives),
        .state     (state),
        .ok        (ok),
        .bad       (bad)
    );

    int total = 0;
    int nbad  = 0;

    int m_state, m_level, m_target, m_tl, m_score, m_lives, m_streak;
    int m_ok, m_bad, m_play, m_res;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game rules: verdict applied the moment the round ends.
    task automatic judge(input bit good);
        m_state = S_RESULT;
        m_res   = 0;
        if (good) begin
            m_ok    = 1;
            m_score = (m_score < 1023) ? m_score + 1 : 1023;
            m_streak++;
            if (m_streak >= STREAK_UP) begin
                if (m_level < MAX_LEVEL) begin
                    m_level++;
                    m_streak = 0;
                end else begin
                    m_streak = STREAK_UP;
                end
            end
        end else begin
            m_bad    = 1;
            m_streak = 0;
            if (m_lives > 0) m_lives--;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = S_IDLE; m_level = 1; m_target = 0; m_tl = 0; m_score = 0;
            m_lives = LIVES_INIT; m_streak = 0; m_ok = 0; m_bad = 0; m_play = 0; m_res = 0;
        end else begin
            case (m_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        m_score = 0; m_streak = 0; m_lives = LIVES_INIT; m_level = 1;
                        m_ok = 0; m_bad = 0; m_state = S_LOAD;
                    end
                end
                S_LOAD: begin
                    m_target = int'(rng_num) % (1 << m_level);
                    m_tl     = ROUND_TICKS;
                    m_play   = 0;
                    m_state  = S_PLAY;
                end
                S_PLAY: begin
                    m_play++;
                    m_tl = ROUND_TICKS - m_play / TICK_DIV;
                    if (m_tl < 0) m_tl = 0;
                    if (submit) judge(int'(sw) == m_target);
                    else if (m_tl == 0) judge(1'b0);
                end
                S_RESULT: begin
                    m_res++;
                    if (m_res == RESULT_CYCLES) begin
                        m_ok = 0; m_bad = 0;
                        m_state = (m_lives == 0) ? S_OVER : S_LOAD;
                    end
                end
                default: m_state = S_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("state", int'(state), m_state);
            check("level", int'(level), m_level);
            check("target", int'(target), m_target);
            check("time_left", int'(time_left), m_tl);
            check("score", int'(score), m_score);
            check("lives", int'(lives), m_lives);
            check("ok", int'(ok), m_ok);
            check("bad", int'(bad), m_bad);
        end
    end

    task automatic wait_model(input int s, input int budget);
        int n = 0;
        while (m_state != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_state != s) begin
            total++;
            nbad++;
            $display("FAIL wait_state: got %0d want %0d at %0t", m_state, s, $time);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode: 0 correct, 1 wrong, 2 timeout, 3 correct low bits with bit 9 set
    task automatic play_round(input int mode, input int delay, input logic [9:0] next_rng);
        int n = 0;
        wait_model(S_PLAY, 4);
        if (mode == 2) begin
            while (state == 3'd2 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycles", n, 20);
            check("timeout_bad", int'(bad), 1);
        end else begin
            repeat (delay) @(negedge clk);
            case (mode)
                0:       sw = 10'(m_target);
                1:       sw = 10'(m_target ^ 1);
                default: sw = 10'(m_target) | 10'h200;
            endcase
            submit = 1'b1;
            @(negedge clk);
            submit = 1'b0;
            if (mode == 0) check("round_ok", int'(ok), 1);
            else           check("round_bad", int'(bad), 1);
        end
        n = 0;
        while (m_state == S_RESULT && n < 10) begin
            @(negedge clk);
            n++;
        end
        rng_num = next_rng;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_state", int'(state), 0);
        check("rst_level", int'(level), 1);
        check("rst_lives", int'(lives), 3);
        check("rst_time", int'(time_left), 0);

        // reset in the middle of a round
        pulse_start();
        wait_model(S_PLAY, 4);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_state", int'(state), 0);
        check("midrst_level", int'(level), 1);
        check("midrst_score", int'(score), 0);
        check("midrst_lives", int'(lives), 3);
        check("midrst_target", int'(target), 0);
        @(negedge clk);
        rst_n = 1'b1;
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        @(negedge clk);
        check("idle_submit_state", int'(state), 0);

        // three correct answers advance to level 2
        rng_num = 10'h3FF;
        pulse_start();
        wait_model(S_PLAY, 4);
        check("lvl1_target", int'(target), 1);
        repeat (3) play_round(0, 6, 10'h3FF);
        @(negedge clk);
        check("lvl2_level", int'(level), 2);
        check("lvl2_score", int'(score), 3);
        check("lvl2_target", int'(target), 3);

        // timeout
        play_round(2, 0, 10'h3FE);
        check("timeout_lives", int'(lives), 2);

        // upper switch bit set makes the answer wrong
        @(negedge clk);
        check("upper_target", int'(target), 2);
        play_round(3, 6, 10'h3FE);
        check("upper_lives", int'(lives), 1);

        // submit on the final tick wins over timeout
        play_round(0, 19, 10'h3FE);
        check("coincide_tl", int'(time_left), 0);
        check("coincide_score", int'(score), 4);

        // last life lost
        play_round(1, 2, 10'h3FE);
        check("over_state", int'(state), 4);
        check("over_lives", int'(lives), 0);
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        @(negedge clk);
        check("over_submit_state", int'(state), 4);
        check("over_score", int'(score), 4);

        pulse_start();
        check("restart_state", int'(state), 1);
        check("restart_lives", int'(lives), 3);
        check("restart_score", int'(score), 0);
        check("restart_level", int'(level), 1);

        // three wrong answers end the game; start is ignored mid-round
        wait_model(S_PLAY, 4);
        pulse_start();
        check("play_start_state", int'(state), 2);
        repeat (3) play_round(1, 1, 10'h3FE);
        check("over2_state", int'(state), 4);
        check("over2_lives", int'(lives), 0);

        // level ceiling
        rng_num = 10'h2A5;
        pulse_start();
        repeat (30) play_round(0, 1, 10'h2A5);
        @(negedge clk);
        check("ceil_level", int'(level), 10);
        check("ceil_score", int'(score), 30);
        check("ceil_target", int'(target), 10'h2A5);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule
